mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_arb_priority.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction-fetch / data-port memory arbiter.
// Holds the FSM state enum, the port-owner enum and the memory word width.
package mem_port_arbiter_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Winner selection between fetch and data ports, with a saturating starvation
// counter that eventually lets a waiting fetch beat the data port.
module arb_priority
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 3
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       ifReq_i,
   input  logic       dmReq_i,
   input  logic       evalEn_i,
   output logic       anyReq_o,
   output owner_t     winner_o,
   output logic [1:0] starveCnt_o
);

   localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

   logic [1:0] starveCnt_q;
   logic [1:0] starveCnt_d;

   // The data port wins ties until the fetch port has lost LIMIT times in a row.
   always_comb begin
      anyReq_o = ifReq_i | dmReq_i;
      winner_o = OWN_DM;
      if (ifReq_i && (!dmReq_i || (starveCnt_q == LIMIT))) begin
         winner_o = OWN_IF;
      end
   end

   always_comb begin
      starveCnt_d = starveCnt_q;
      if (evalEn_i && anyReq_o) begin
         if (winner_o == OWN_IF) begin
            starveCnt_d = 2'd0;
         end else if (ifReq_i && (starveCnt_q != 2'd3)) begin
            starveCnt_d = starveCnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         starveCnt_q <= 2'd0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end

   assign starveCnt_o = starveCnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: fetch and data ports share a single-cycle memory.
// Each access takes IDLE -> ACCESS -> DONE, acknowledging the owner in DONE.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 3
) (
   input  logic              In_clock,
   input  logic              In_reset,
   input  logic              In_IF_req,
   input  logic [WORD_W-1:0] In_IF_addr,
   output logic              Out_IF_ack,
   output logic [WORD_W-1:0] Out_IF_rdata,
   input  logic              In_DM_req,
   input  logic              In_DM_R_Wbar,
   input  logic [WORD_W-1:0] In_DM_addr,
   input  logic [WORD_W-1:0] In_DM_wdata,
   output logic              Out_DM_ack,
   output logic [WORD_W-1:0] Out_DM_rdata,
   output logic              Out_Mem_Access_en,
   output logic              Out_Mem_Access_R_Wbar,
   output logic [WORD_W-1:0] Out_Mem_Access_addr,
   output logic [WORD_W-1:0] Out_Mem_Write_data,
   input  logic [WORD_W-1:0] In_Mem_Read_data,
   output logic              Out_busy
);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              rw_q, rw_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [WORD_W-1:0] ifRdata_q, ifRdata_d;
   logic [WORD_W-1:0] dmRdata_q, dmRdata_d;

   logic              anyReq;
   owner_t            winner;
   logic [1:0]        starveCnt;

   arb_priority #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) uArb (
      .clock_i    (In_clock),
      .reset_i    (In_reset),
      .ifReq_i    (In_IF_req),
      .dmReq_i    (In_DM_req),
      .evalEn_i   (state_q == IDLE),
      .anyReq_o   (anyReq),
      .winner_o   (winner),
      .starveCnt_o(starveCnt)
   );

   // Request fields are captured only in IDLE, so later input changes cannot
   // disturb an access in flight.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ifRdata_d = ifRdata_q;
      dmRdata_d = dmRdata_q;
      unique case (state_q)
         IDLE: begin
            if (anyReq) begin
               owner_d = winner;
               state_d = ACCESS;
               if (winner == OWN_IF) begin
                  rw_d   = 1'b1;
                  addr_d = In_IF_addr;
               end else begin
                  rw_d    = In_DM_R_Wbar;
                  addr_d  = In_DM_addr;
                  wdata_d = In_DM_wdata;
               end
            end
         end
         ACCESS: begin
            state_d = DONE;
            if (rw_q) begin
               if (owner_q == OWN_IF) begin
                  ifRdata_d = In_Mem_Read_data;
               end else begin
                  dmRdata_d = In_Mem_Read_data;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge In_clock or posedge In_reset) begin
      if (In_reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_DM;
         rw_q      <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         ifRdata_q <= '0;
         dmRdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ifRdata_q <= ifRdata_d;
         dmRdata_q <= dmRdata_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign Out_Mem_Access_en     = (state_q == ACCESS);
   assign Out_IF_ack            = (state_q == DONE) && (owner_q == OWN_IF);
   assign Out_DM_ack            = (state_q == DONE) && (owner_q == OWN_DM);
   assign Out_busy              = (state_q != IDLE);
   assign Out_Mem_Access_R_Wbar = rw_q;
   assign Out_Mem_Access_addr   = addr_q;
   assign Out_Mem_Write_data    = wdata_q;
   assign Out_IF_rdata          = ifRdata_q;
   assign Out_DM_rdata          = dmRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small read-only
// memory model; inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifReq, dmReq, dmRW;
   logic [15:0] ifAddr, dmAddr, dmWdata;
   logic        ifAck, dmAck, memEn, memRW, busy;
   logic [15:0] ifRdata, dmRdata, memAddr, memWdata, memRdata;
   int          total = 0;
   int          bad = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
      .In_clock             (clock),
      .In_reset             (reset),
      .In_IF_req            (ifReq),
      .In_IF_addr           (ifAddr),
      .Out_IF_ack           (ifAck),
      .Out_IF_rdata         (ifRdata),
      .In_DM_req            (dmReq),
      .In_DM_R_Wbar         (dmRW),
      .In_DM_addr           (dmAddr),
      .In_DM_wdata          (dmWdata),
      .Out_DM_ack           (dmAck),
      .Out_DM_rdata         (dmRdata),
      .Out_Mem_Access_en    (memEn),
      .Out_Mem_Access_R_Wbar(memRW),
      .Out_Mem_Access_addr  (memAddr),
      .Out_Mem_Write_data   (memWdata),
      .In_Mem_Read_data     (memRdata),
      .Out_busy             (busy)
   );

   always_comb begin
      case (memAddr)
         16'h0014: memRdata = 16'h0001;
         16'h0015: memRdata = 16'h000F;
         16'h0017: memRdata = 16'hFFFF;
         default:  memRdata = 16'hDEAD;
      endcase
   end

   task automatic test_reset();
      reset = 1'b1; ifReq = 1'b0; dmReq = 1'b0; dmRW = 1'b1;
      ifAddr = 16'h0; dmAddr = 16'h0; dmWdata = 16'h0;
      repeat (2) @(negedge clock);
      total++; if (memEn !== 1'b0) begin bad++; $display("[TB] FAIL reset_en got=%b want=0", memEn); end
      total++; if (memRW !== 1'b1) begin bad++; $display("[TB] FAIL reset_rw got=%b want=1", memRW); end
      total++; if (memAddr !== 16'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0000", memAddr); end
      total++; if (memWdata !== 16'h0) begin bad++; $display("[TB] FAIL reset_wdata got=%h want=0000", memWdata); end
      total++; if ({ifAck, dmAck, busy} !== 3'b000) begin bad++; $display("[TB] FAIL reset_acks_busy got=%b want=000", {ifAck, dmAck, busy}); end
      total++; if ({ifRdata, dmRdata} !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=00000000", {ifRdata, dmRdata}); end
      reset = 1'b0;
   endtask

   task automatic test_if_read();
      @(negedge clock); ifReq = 1'b1; ifAddr = 16'h0015;
      @(negedge clock);
      total++; if ({memEn, memRW, busy, ifAck} !== 4'b1110) begin bad++; $display("[TB] FAIL if_access_ctl got=%b want=1110", {memEn, memRW, busy, ifAck}); end
      total++; if (memAddr !== 16'h0015) begin bad++; $display("[TB] FAIL if_access_addr got=%h want=0015", memAddr); end
      ifAddr = 16'h0099;
      @(negedge clock);
      total++; if ({ifAck, dmAck, memEn} !== 3'b100) begin bad++; $display("[TB] FAIL if_done_ack got=%b want=100", {ifAck, dmAck, memEn}); end
      total++; if (ifRdata !== 16'h000F) begin bad++; $display("[TB] FAIL if_rdata got=%h want=000F", ifRdata); end
      total++; if (dmRdata !== 16'h0000) begin bad++; $display("[TB] FAIL if_dm_rdata_kept got=%h want=0000", dmRdata); end
      total++; if (memAddr !== 16'h0015) begin bad++; $display("[TB] FAIL if_addr_hold got=%h want=0015", memAddr); end
      ifReq = 1'b0;
      @(negedge clock);
      total++; if ({ifAck, busy} !== 2'b00) begin bad++; $display("[TB] FAIL if_idle got=%b want=00", {ifAck, busy}); end
   endtask

   task automatic test_dm_write();
      @(negedge clock); dmReq = 1'b1; dmRW = 1'b0; dmAddr = 16'h0016; dmWdata = 16'hABCD;
      @(negedge clock);
      total++; if ({memEn, memRW} !== 2'b10) begin bad++; $display("[TB] FAIL wr_access_ctl got=%b want=10", {memEn, memRW}); end
      total++; if ({memAddr, memWdata} !== 32'h0016ABCD) begin bad++; $display("[TB] FAIL wr_addr_data got=%h want=0016ABCD", {memAddr, memWdata}); end
      dmWdata = 16'h1111;
      @(negedge clock);
      total++; if ({dmAck, ifAck, memEn} !== 3'b100) begin bad++; $display("[TB] FAIL wr_done_ack got=%b want=100", {dmAck, ifAck, memEn}); end
      total++; if ({ifRdata, dmRdata} !== 32'h000F0000) begin bad++; $display("[TB] FAIL wr_rdata_kept got=%h want=000F0000", {ifRdata, dmRdata}); end
      total++; if (memWdata !== 16'hABCD) begin bad++; $display("[TB] FAIL wr_wdata_hold got=%h want=ABCD", memWdata); end
      dmReq = 1'b0; dmRW = 1'b1;
      @(negedge clock);
      total++; if ({dmAck, busy} !== 2'b00) begin bad++; $display("[TB] FAIL wr_idle got=%b want=00", {dmAck, busy}); end
   endtask

   task automatic test_back_to_back();
      int k;
      @(negedge clock); dmReq = 1'b1; dmRW = 1'b1; dmAddr = 16'h0014;
      @(negedge clock);
      @(negedge clock);
      total++; if ({dmAck, dmRdata} !== {1'b1, 16'h0001}) begin bad++; $display("[TB] FAIL b2b_first got=%b/%h want=1/0001", dmAck, dmRdata); end
      dmAddr = 16'h0017;
      k = 0;
      do begin @(negedge clock); k++; end while (!dmAck && k < 6);
      dmReq = 1'b0;
      total++; if (k !== 3 || dmAck !== 1'b1) begin bad++; $display("[TB] FAIL b2b_gap got=%0d ack=%b want=3 ack=1", k, dmAck); end
      total++; if (dmRdata !== 16'hFFFF) begin bad++; $display("[TB] FAIL b2b_second got=%h want=FFFF", dmRdata); end
      @(negedge clock);
   endtask

   task automatic test_starvation();
      logic expIf[5];
      logic [1:0] expCnt[5];
      expIf  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      expCnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      @(negedge clock);
      ifReq = 1'b1; ifAddr = 16'h0015; dmReq = 1'b1; dmRW = 1'b1; dmAddr = 16'h0014;
      for (int g = 0; g < 5; g++) begin
         total++; if (dut.uArb.starveCnt_q !== expCnt[g]) begin bad++; $display("[TB] FAIL starve_cnt_%0d got=%0d want=%0d", g, dut.uArb.starveCnt_q, expCnt[g]); end
         @(negedge clock);
         @(negedge clock);
         total++; if ({ifAck, dmAck} !== {expIf[g], ~expIf[g]}) begin bad++; $display("[TB] FAIL grant_%0d got=%b want=%b", g, {ifAck, dmAck}, {expIf[g], ~expIf[g]}); end
         if (g == 4) begin ifReq = 1'b0; dmReq = 1'b0; end
         @(negedge clock);
      end
      total++; if (dut.uArb.starveCnt_q !== 2'd1) begin bad++; $display("[TB] FAIL starve_end got=%0d want=1", dut.uArb.starveCnt_q); end
      total++; if ({ifRdata, dmRdata} !== 32'h000F0001) begin bad++; $display("[TB] FAIL starve_rdata got=%h want=000F0001", {ifRdata, dmRdata}); end
   endtask

   task automatic test_req_held();
      @(negedge clock); dmReq = 1'b1; dmRW = 1'b1; dmAddr = 16'h0017;
      @(negedge clock);
      @(negedge clock);
      total++; if (dmAck !== 1'b1) begin bad++; $display("[TB] FAIL held_first_ack got=%b want=1", dmAck); end
      @(negedge clock);
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL held_idle got=%b want=0", busy); end
      @(negedge clock);
      total++; if ({memEn, memAddr} !== {1'b1, 16'h0017}) begin bad++; $display("[TB] FAIL held_regrant got=%b/%h want=1/0017", memEn, memAddr); end
      dmReq = 1'b0;
      @(negedge clock);
      total++; if (dmAck !== 1'b1) begin bad++; $display("[TB] FAIL held_second_ack got=%b want=1", dmAck); end
      repeat (2) @(negedge clock);
      total++; if ({memEn, busy, dmAck} !== 3'b000) begin bad++; $display("[TB] FAIL held_no_third got=%b want=000", {memEn, busy, dmAck}); end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clock); dmReq = 1'b1; dmRW = 1'b1; dmAddr = 16'h0014;
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      total++; if ({memEn, busy, ifAck, dmAck, memRW} !== 5'b00001) begin bad++; $display("[TB] FAIL rst_mid_ctl got=%b want=00001", {memEn, busy, ifAck, dmAck, memRW}); end
      total++; if ({memAddr, memWdata, ifRdata, dmRdata} !== 64'h0) begin bad++; $display("[TB] FAIL rst_mid_regs got=%h want=0", {memAddr, memWdata, ifRdata, dmRdata}); end
      dmReq = 1'b0;
      @(negedge clock);
      total++; if ({ifAck, dmAck} !== 2'b00) begin bad++; $display("[TB] FAIL rst_mid_noack got=%b want=00", {ifAck, dmAck}); end
      reset = 1'b0;
      @(negedge clock); dmReq = 1'b1; dmAddr = 16'h0015;
      @(negedge clock);
      total++; if (memEn !== 1'b1) begin bad++; $display("[TB] FAIL rst_after_en got=%b want=1", memEn); end
      @(negedge clock);
      total++; if ({dmAck, dmRdata} !== {1'b1, 16'h000F}) begin bad++; $display("[TB] FAIL rst_after_read got=%b/%h want=1/000F", dmAck, dmRdata); end
      dmReq = 1'b0;
      @(negedge clock);
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_after_idle got=%b want=0", busy); end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_dm_write();
      test_back_to_back();
      test_starvation();
      test_req_held();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Mutual exclusion of the two acks is watched on every cycle.
   always @(negedge clock) begin
      if (ifAck && dmAck) begin
         bad++;
         $display("[TB] FAIL both_acks got=11 want=not both");
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
